// File: rtl/noc_xbar.sv
// noc_xbar: terminates the per-CPU push/pull channels. Every source port owns
// an ingress FIFO; each head word is routed by the destination byte in its top
// bits to a per-destination output register, with a round-robin arbiter per
// destination. Heads addressed outside the port range are discarded and counted.
module noc_xbar #(
   parameter int N_CPU      = 4,
   parameter int DATA_WIDTH = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_CPU-1:0]              data_cpu_to_noc_vld,
   output logic [N_CPU-1:0]              data_cpu_to_noc_rdy,
   input  logic [N_CPU*DATA_WIDTH-1:0]   data_cpu_to_noc,
   output logic [N_CPU-1:0]              data_noc_to_cpu_vld,
   input  logic [N_CPU-1:0]              data_noc_to_cpu_rdy,
   output logic [N_CPU*DATA_WIDTH-1:0]   data_noc_to_cpu,
   output logic [31:0]                   drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(N_CPU);

   // Ingress FIFO storage and bookkeeping, one set per source port
   logic [DATA_WIDTH-1:0] fifo_mem  [N_CPU][FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr    [N_CPU];
   logic [AW-1:0]         wr_ptr    [N_CPU];
   logic [CW-1:0]         fifo_cnt  [N_CPU];

   logic [N_CPU-1:0]      push;
   logic [N_CPU-1:0]      pop;
   logic [N_CPU-1:0]      drop;
   logic [N_CPU-1:0]      head_vld;
   logic [DATA_WIDTH-1:0] head_data [N_CPU];
   logic [7:0]            head_dest [N_CPU];

   // Per-destination request/grant vectors, indexed [destination][source]
   logic [N_CPU-1:0]      req       [N_CPU];
   logic [N_CPU-1:0]      grant     [N_CPU];
   logic [N_CPU-1:0]      free;
   logic [SW-1:0]         prio      [N_CPU];
   logic [SW-1:0]         next_prio [N_CPU];
   logic [DATA_WIDTH-1:0] load_data [N_CPU];
   logic [DATA_WIDTH-1:0] out_data  [N_CPU];

   logic [32:0]           drop_sum;

   // Ready depends only on the registered occupancy, never on the incoming valid
   always_comb begin
      for (int s = 0; s < N_CPU; s++) begin
         data_cpu_to_noc_rdy[s] = (fifo_cnt[s] != CW'(FIFO_DEPTH));
      end
      push = data_cpu_to_noc_vld & data_cpu_to_noc_rdy;
   end

   // Decode each FIFO head: its destination, whether it must be dropped, and
   // which destination it is requesting
   always_comb begin
      for (int s = 0; s < N_CPU; s++) begin
         head_vld[s]  = (fifo_cnt[s] != '0);
         head_data[s] = fifo_mem[s][rd_ptr[s]];
         head_dest[s] = head_data[s][DATA_WIDTH-1 -: 8];
         drop[s]      = head_vld[s] && (head_dest[s] >= 8'(N_CPU));
      end
      for (int d = 0; d < N_CPU; d++) begin
         for (int s = 0; s < N_CPU; s++) begin
            req[d][s] = head_vld[s] && (head_dest[s] == 8'(d));
         end
      end
   end

   // Round-robin search from each destination's pointer; a destination only
   // grants when its output register is empty or being drained this cycle
   always_comb begin : arb
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      for (int d = 0; d < N_CPU; d++) begin
         free[d]      = !data_noc_to_cpu_vld[d] || data_noc_to_cpu_rdy[d];
         grant[d]     = '0;
         next_prio[d] = prio[d];
         load_data[d] = '0;
         found        = 1'b0;
         for (int k = 0; k < N_CPU; k++) begin
            idx = (int'(prio[d]) + k) % N_CPU;
            if (!found && free[d] && req[d][idx]) begin
               found          = 1'b1;
               grant[d][idx]  = 1'b1;
               next_prio[d]   = SW'((idx + 1) % N_CPU);
               load_data[d]   = head_data[idx];
            end
         end
      end
   end

   // A head leaves its FIFO either by being dropped or by winning its destination
   always_comb begin
      pop = drop;
      for (int d = 0; d < N_CPU; d++) begin
         pop = pop | grant[d];
      end
   end

   // FIFO payload storage needs no reset; occupancy tracking guards every read
   always_ff @(posedge clk) begin
      for (int s = 0; s < N_CPU; s++) begin
         if (push[s]) begin
            fifo_mem[s][wr_ptr[s]] <= data_cpu_to_noc[s*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // FIFO pointers and counts; push and pop may happen in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < N_CPU; s++) begin
            rd_ptr[s]   <= '0;
            wr_ptr[s]   <= '0;
            fifo_cnt[s] <= '0;
         end
      end else begin
         for (int s = 0; s < N_CPU; s++) begin
            if (push[s]) wr_ptr[s] <= wr_ptr[s] + AW'(1);
            if (pop[s])  rd_ptr[s] <= rd_ptr[s] + AW'(1);
            fifo_cnt[s] <= fifo_cnt[s] + CW'(push[s]) - CW'(pop[s]);
         end
      end
   end

   // Output registers and arbitration pointers; a drained register is refilled
   // in the same edge so a busy destination streams without bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_noc_to_cpu_vld <= '0;
         for (int d = 0; d < N_CPU; d++) begin
            out_data[d] <= '0;
            prio[d]     <= '0;
         end
      end else begin
         for (int d = 0; d < N_CPU; d++) begin
            if (free[d]) begin
               data_noc_to_cpu_vld[d] <= |grant[d];
               if (|grant[d]) out_data[d] <= load_data[d];
               prio[d] <= next_prio[d];
            end
         end
      end
   end

   // Pack the per-destination registers onto the flat egress bus
   always_comb begin
      data_noc_to_cpu = '0;
      for (int d = 0; d < N_CPU; d++) begin
         data_noc_to_cpu[d*DATA_WIDTH +: DATA_WIDTH] = out_data[d];
      end
   end

   // Several FIFOs may drop in the same cycle, so add the number of drops
   always_comb begin
      drop_sum = {1'b0, drop_count} + 33'($countones(drop));
   end

   // Saturating count of discarded words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count <= '0;
      end else if (|drop) begin
         drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      end
   end

endmodule
